seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Time-multiplexed seven-segment scan driver for the Nexys A7 8-digit display. It generalises the team's parametrised n-bit decoder into a sequential block. A refresh counter steps a digit index through NUM_DIGITS slots, and the index is decoded to a one-hot active-low anode. Segment data comes from a per-frame snapshot, and a blanking interval at the start of each slot suppresses ghosting.

Parameters:
NUM_DIGITS, 8, digit count; legal values 2, 4, 8.
SEL_WIDTH, 3, digit index width; must equal log2(NUM_DIGITS).
DIV_WIDTH, 17, slot counter width; must hold REFRESH_DIV-1.
REFRESH_DIV, 100000, clocks per digit slot (1 kHz per digit at 100 MHz).
BLANK_CYCLES, 1000, anodes-off clocks at the start of each slot; legal range 1..REFRESH_DIV-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable
digits_in  in  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i]
dig_en  in  NUM_DIGITS  per-digit display enable
dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit
an_n  out  NUM_DIGITS  anodes, active-low
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
digit_sel  out  SEL_WIDTH  current digit index
frame_tick  out  1  one-clock pulse at each frame start

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values (applied asynchronously): an_n all 1, seg_n 7'h7F, dp_n 1, digit_sel 0, frame_tick 0, slot counter 0, state IDLE, snapshot registers 0.
- States are IDLE, BLANK and DRIVE; the slot counter cnt runs 0..REFRESH_DIV-1.
- IDLE: all outputs are off. When en=1, the next state is BLANK with cnt=0 and digit_sel=0. The snapshot is captured on the same clock and frame_tick pulses.
- BLANK: an_n all 1, seg_n 7'h7F, dp_n 1. cnt increments each clock. When cnt==BLANK_CYCLES-1, the next state is DRIVE.
- DRIVE: an_n has bit digit_sel low only if dig_en_snap[digit_sel]=1; otherwise an_n stays all 1. seg_n = hex_to_7seg(snapshot nibble[digit_sel]). dp_n = ~dp_snap[digit_sel], forced to 1 when the digit is disabled.
- DRIVE slot end: at cnt==REFRESH_DIV-1, cnt goes to 0, digit_sel increments modulo NUM_DIGITS, and the next state is BLANK.
- Frame wrap: when digit_sel wraps from NUM_DIGITS-1 to 0, frame_tick is high for exactly that one clock and digits_in, dig_en and dp_in are re-snapshotted.
- Input changes between snapshots are invisible until the next frame (no tearing).
- en=0 in any state: next state IDLE, cnt=0, digit_sel=0.
- Re-enabling after IDLE always restarts at digit 0 in BLANK with a fresh snapshot.
- Output timing: an_n, seg_n and dp_n are registered and glitch-free. Each reflects the state, digit_sel and snapshot of the previous clock, i.e. one clock of latency.
- digit_sel and frame_tick are direct register outputs.
- Hex table (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset asserted mid-slot: all outputs go immediately to their reset values. After release, the block re-enters IDLE and then BLANK on the first clock with en=1.

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum (IDLE, BLANK, DRIVE);
  - constant SEG_OFF = 7'h7F;
  - the 16-entry hex-to-segment constant table.
- Sub-module hex_to_7seg: purely combinational 4-bit nibble to 7-bit active-low segments.
- Anode generation is an inline enabled one-hot-low decode of digit_sel.

Test Plan:
All scenarios use NUM_DIGITS=4, SEL_WIDTH=2, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Assert rst_n=0 mid-DRIVE -> an_n=4'b1111, seg_n=7'h7F, dp_n=1, digit_sel=0 asynchronously. After release with en=0, outputs stay off.
2. digits_in=16'h3210, dig_en=4'hF, en=1 -> each 8-clock slot shows 2 clocks of an_n=1111, then 6 clocks of an_n=1110/seg 1000000, 1101/1111001, 1011/0100100, 0111/0110000 in turn. frame_tick fires every 32 clocks.
3. dig_en=4'b0101 -> digits 1 and 3 keep an_n=1111 for all 8 clocks of their slots, while digit_sel still steps 0,1,2,3.
4. Change digits_in from 16'h3210 to 16'hFFFF during digit 1 -> digits 2 and 3 still show 0100100 and 0110000. The next frame shows 0001110 on all digits.
5. Drop en during digit 2 DRIVE -> an_n=1111 within 2 clocks and digit_sel=0. Raising en again restarts at digit 0 BLANK with frame_tick=1.
6. dp_in=4'b1000 -> dp_n=0 only during digit 3 DRIVE clocks, and 1 at all other times, including digit 3 BLANK.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_scan_pkg;

  // Scan FSM states: IDLE (outputs off), BLANK (anti-ghost gap), DRIVE (digit lit).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns {g,f,e,d,c,b,a}, listed from nibble F down to 0
  // so that HEX_TABLE[n] selects the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_scan_decoder_hex.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_decoder.sv
// Time-multiplexed seven-segment scan driver with per-frame input snapshot
// and a blanking gap at the start of every digit slot.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SEL_WIDTH    = 3,
  parameter int DIV_WIDTH    = 17,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [SEL_WIDTH-1:0]    digit_sel,
  output logic                    frame_tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_BLANK_END = DIV_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_SLOT_END  = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST      = SEL_WIDTH'(NUM_DIGITS - 1);

  state_e                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic                      frame_tick_q, frame_tick_d;
  logic [4*NUM_DIGITS-1:0]   digits_snap_q, digits_snap_d;
  logic [NUM_DIGITS-1:0]     dig_en_snap_q, dig_en_snap_d;
  logic [NUM_DIGITS-1:0]     dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
  logic [6:0]                seg_n_q, seg_n_d;
  logic                      dp_n_q, dp_n_d;

  logic [3:0]                cur_nibble;
  logic [6:0]                cur_seg;

  // Nibble of the digit currently being scanned, taken from the frame snapshot.
  assign cur_nibble = digits_snap_q[{sel_q, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .nibble_i (cur_nibble),
    .seg_n_o  (cur_seg)
  );

  // Next-state logic: slot counter, digit index, frame tick and snapshot capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    frame_tick_d  = 1'b0;
    digits_snap_d = digits_snap_q;
    dig_en_snap_d = dig_en_snap_q;
    dp_snap_d     = dp_snap_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = BLANK;
          cnt_d         = '0;
          sel_d         = '0;
          frame_tick_d  = 1'b1;
          digits_snap_d = digits_in;
          dig_en_snap_d = dig_en;
          dp_snap_d     = dp_in;
        end
        BLANK: begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
          if (cnt_q == CNT_BLANK_END) begin
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_SLOT_END) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (sel_q == SEL_LAST) begin
              // Frame wrap: new snapshot so a whole frame shows consistent data.
              sel_d         = '0;
              frame_tick_d  = 1'b1;
              digits_snap_d = digits_in;
              dig_en_snap_d = dig_en;
              dp_snap_d     = dp_in;
            end else begin
              sel_d = sel_q + SEL_WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = '0;
        end
      endcase
    end
  end

  // Enabled one-hot-low anode decode; only the scanned, enabled digit in DRIVE goes low.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_n_d[gi] = ~((state_q == DRIVE) && (sel_q == SEL_WIDTH'(gi)) && dig_en_snap_q[gi]);
    end
  endgenerate

  // Segment and decimal-point values for the next registered output.
  always_comb begin
    seg_n_d = SEG_OFF;
    dp_n_d  = 1'b1;
    if (state_q == DRIVE) begin
      seg_n_d = cur_seg;
      if (dig_en_snap_q[sel_q]) begin
        dp_n_d = ~dp_snap_q[sel_q];
      end
    end
  end

  // State, snapshot and glitch-free output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      frame_tick_q  <= 1'b0;
      digits_snap_q <= '0;
      dig_en_snap_q <= '0;
      dp_snap_q     <= '0;
      an_n_q        <= '1;
      seg_n_q       <= SEG_OFF;
      dp_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      frame_tick_q  <= frame_tick_d;
      digits_snap_q <= digits_snap_d;
      dig_en_snap_q <= dig_en_snap_d;
      dp_snap_q     <= dp_snap_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign digit_sel  = sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder (4 digits, 8-clock slots, 2 blank clocks).
module tb_seg_scan_decoder;

  localparam int ND  = 4;
  localparam int SW  = 2;
  localparam int DW  = 3;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [15:0]   digits_in;
  logic [3:0]    dig_en;
  logic [3:0]    dp_in;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [1:0]    digit_sel;
  logic          frame_tick;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .NUM_DIGITS   (ND),
    .SEL_WIDTH    (SW),
    .DIV_WIDTH    (DW),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits_in  (digits_in),
    .dig_en     (dig_en),
    .dp_in      (dp_in),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] sel;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Hand-written segment table, gfedcba active-low, indexed by nibble.
  logic [6:0] hex_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Inputs the bench applied for frame 0, 1 and 2 of the current run.
  logic [15:0] fr_dig [3];
  logic [3:0]  fr_en  [3];
  logic [3:0]  fr_dp  [3];

  exp_t off_vec;

  task automatic check(input string name, input int c, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
    end
  endtask

  // Expected outputs m clocks after the IDLE->BLANK edge of a run.
  // Slot timeline: 2 blank clocks then 6 drive clocks; pins lag the state by one clock.
  function automatic exp_t exp_at(input int m);
    exp_t       e;
    int         p, d, f;
    logic [3:0] one;
    logic [15:0] dg;
    one   = 4'b0001;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.sel = 2'((m / 8) % 4);
    e.ft  = ((m % 32) == 0);
    if (m >= 1) begin
      p = (m - 1) % 8;
      d = ((m - 1) / 8) % 4;
      f = (m - 1) / 32;
      if (f > 2) f = 2;
      if (p >= 2) begin
        dg    = fr_dig[f];
        e.seg = hex_ref[dg[d*4 +: 4]];
        if (fr_en[f][d]) begin
          e.an = ~(one << d);
          e.dp = ~fr_dp[f][d];
        end
      end
    end
    return e;
  endfunction

  task automatic push_vec(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step(input int m);
    push_vec(exp_at(m));
  endtask

  // Monitor: one expected vector is consumed per clock while the queue is non-empty.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("an_n",       cyc, 16'(an_n),       16'(mon_e.an));
      check("seg_n",      cyc, 16'(seg_n),      16'(mon_e.seg));
      check("dp_n",       cyc, 16'(dp_n),       16'(mon_e.dp));
      check("digit_sel",  cyc, 16'(digit_sel),  16'(mon_e.sel));
      check("frame_tick", cyc, 16'(frame_tick), 16'(mon_e.ft));
      $display("cyc=%0d an_n=%b seg_n=%b dp_n=%b sel=%0d ft=%b", cyc, an_n, seg_n, dp_n, digit_sel, frame_tick);
    end
  end

  initial begin
    off_vec   = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, sel: 2'd0, ft: 1'b0};
    rst_n     = 1'b0;
    en        = 1'b0;
    digits_in = 16'h0000;
    dig_en    = 4'h0;
    dp_in     = 4'h0;

    // Reset state.
    #12;
    check("rst_an_n",  0, 16'(an_n),       16'hF);
    check("rst_seg_n", 0, 16'(seg_n),      16'h7F);
    check("rst_dp_n",  0, 16'(dp_n),       16'h1);
    check("rst_sel",   0, 16'(digit_sel),  16'h0);
    check("rst_ft",    0, 16'(frame_tick), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push_vec(off_vec);

    // Run A: digits 3210, all enabled, dp on digit 3; digits change to FFFF mid-frame.
    fr_dig[0] = 16'h3210; fr_dig[1] = 16'hFFFF; fr_dig[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin fr_en[i] = 4'hF; fr_dp[i] = 4'b1000; end
    digits_in = 16'h3210;
    dig_en    = 4'hF;
    dp_in     = 4'b1000;
    en        = 1'b1;
    for (int m = 0; m < 72; m++) begin
      if (m == 12) digits_in = 16'hFFFF;
      step(m);
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Run B: digits 1 and 3 disabled; en dropped during digit 2 drive of the second frame.
    for (int i = 0; i < 3; i++) begin fr_dig[i] = 16'h3210; fr_en[i] = 4'b0101; fr_dp[i] = 4'h0; end
    digits_in = 16'h3210;
    dig_en    = 4'b0101;
    dp_in     = 4'h0;
    en        = 1'b1;
    for (int m = 0; m < 53; m++) step(m);
    en = 1'b0;
    begin
      exp_t e;
      e     = exp_at(53);
      e.sel = 2'd0;
      e.ft  = 1'b0;
      push_vec(e);
    end
    push_vec(off_vec);
    en = 1'b1;
    for (int m = 0; m < 12; m++) step(m);

    // Asynchronous reset in the middle of digit 1 drive.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an_n",  cyc, 16'(an_n),       16'hF);
    check("async_seg_n", cyc, 16'(seg_n),      16'h7F);
    check("async_dp_n",  cyc, 16'(dp_n),       16'h1);
    check("async_sel",   cyc, 16'(digit_sel),  16'h0);
    check("async_ft",    cyc, 16'(frame_tick), 16'h0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_vec(off_vec);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", cyc, 16'(exp_q.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
